// File: rtl/riscv_pkg.sv
// Shared writeback types and sizes.
// Provides XLEN/NUM_REGS/REG_ADDR_W, the MEM/WB payload struct and the
// writeback data select helper used by the register-file top level.
package riscv_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W_DEF  = 64;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // MEM/WB payload; the valid bit lives beside it so flush can clear it alone
  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    reg_addr_t rd;
    xlen_t     alu_result;
    xlen_t     mem_data;
  } mem_wb_t;

  // Writeback mux: load data or ALU result
  function automatic xlen_t wb_select(input mem_wb_t p);
    return p.mem_to_reg ? p.mem_data : p.alu_result;
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM-stage / decode side bus of the writeback register file.
// master: pipeline side (drives MEM results, stall/flush, read addresses)
// slave : writeback_regfile (returns read data, register array, wb_* view,
//         retire counter)
interface writeback_regfile_if
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic                            in_valid;
  logic                            stall;
  logic                            flush;
  xlen_t                           alu_result;
  xlen_t                           mem_read_data;
  reg_addr_t                       write_addr;
  logic                            RegWrite;
  logic                            MemtoReg;
  reg_addr_t                       rs1_addr;
  reg_addr_t                       rs2_addr;
  xlen_t                           rs1_data;
  xlen_t                           rs2_data;
  logic [NUM_REGS-1:0][XLEN-1:0]   register;
  logic                            wb_valid;
  reg_addr_t                       wb_addr;
  xlen_t                           wb_data;
  logic [CNT_W-1:0]                retire_count;

  modport master (
    output in_valid, stall, flush, alu_result, mem_read_data, write_addr,
           RegWrite, MemtoReg, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, register, wb_valid, wb_addr, wb_data,
           retire_count
  );

  modport slave (
    input  in_valid, stall, flush, alu_result, mem_read_data, write_addr,
           RegWrite, MemtoReg, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, register, wb_valid, wb_addr, wb_data,
           retire_count
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with stall hold, flush and async reset.
// Ports: clk, reset (async, active-high), stall_i (hold), flush_i (clear
// valid, wins over stall), valid_i/data_i (MEM stage), valid_o/data_o.
module mem_wb_reg #(
  parameter type T = riscv_pkg::mem_wb_t
) (
  input  logic clk,
  input  logic reset,
  input  logic stall_i,
  input  logic flush_i,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);

  logic valid_q;
  T     data_q;

  // Valid: flush clears even under stall; otherwise load unless stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (!stall_i) begin
        valid_q <= valid_i;
      end
      if (!stall_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage + integer register file.
// Ports: clk, reset (async, active-high), bus (slave modport): MEM-stage
// results and stall/flush in, bypassed read ports, full register array,
// MEM/WB view (wb_valid/wb_addr/wb_data) and retired-write counter out.
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  writeback_regfile_if.slave   bus
);

  mem_wb_t                       in_pl;
  mem_wb_t                       wb_pl;
  logic                          wb_in_valid;
  logic                          wb_valid;
  xlen_t                         wb_data;
  logic                          commit;
  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [CNT_W-1:0]              retire_q;
  logic [CNT_W-1:0]              retire_d;
  xlen_t                         rs1_rd;
  xlen_t                         rs2_rd;

  // Pack MEM-stage fields into the pipeline payload
  always_comb begin
    in_pl            = '0;
    in_pl.reg_write  = bus.RegWrite;
    in_pl.mem_to_reg = bus.MemtoReg;
    in_pl.rd         = bus.write_addr;
    in_pl.alu_result = bus.alu_result;
    in_pl.mem_data   = bus.mem_read_data;
  end

  mem_wb_reg #(.T(mem_wb_t)) u_mem_wb (
    .clk     (clk),
    .reset   (reset),
    .stall_i (bus.stall),
    .flush_i (bus.flush),
    .valid_i (bus.in_valid),
    .data_i  (in_pl),
    .valid_o (wb_in_valid),
    .data_o  (wb_pl)
  );

  // Writes to x0 are dropped here, so they never commit or count
  assign wb_valid = wb_in_valid & wb_pl.reg_write & (wb_pl.rd != '0);
  assign wb_data  = wb_select(wb_pl);
  assign commit   = wb_valid & ~bus.stall;

  // Register array; entry 0 is reset and never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else if (commit) begin
      regs_q[wb_pl.rd] <= wb_data;
    end
  end

  // Retired-write counter, wraps naturally
  always_comb begin
    retire_d = retire_q;
    if (commit) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  // Read ports: x0 is zero, otherwise the pending MEM/WB value wins
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (bus.rs1_addr != '0) begin
      rs1_rd = (wb_valid && (wb_pl.rd == bus.rs1_addr)) ? wb_data : regs_q[bus.rs1_addr];
    end
    if (bus.rs2_addr != '0) begin
      rs2_rd = (wb_valid && (wb_pl.rd == bus.rs2_addr)) ? wb_data : regs_q[bus.rs2_addr];
    end
  end

  assign bus.rs1_data     = rs1_rd;
  assign bus.rs2_data     = rs2_rd;
  assign bus.register     = regs_q;
  assign bus.wb_valid     = wb_valid;
  assign bus.wb_addr      = wb_pl.rd;
  assign bus.wb_data      = wb_data;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// A second instance with a 3-bit retire counter exercises counter wrap.
module tb_writeback_regfile;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  writeback_regfile_if #(.CNT_W(64)) bus_a ();
  writeback_regfile_if #(.CNT_W(3))  bus_b ();

  writeback_regfile #(.CNT_W(64)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  writeback_regfile #(.CNT_W(3))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.in_valid      = bus_a.in_valid;
  assign bus_b.stall         = bus_a.stall;
  assign bus_b.flush         = bus_a.flush;
  assign bus_b.alu_result    = bus_a.alu_result;
  assign bus_b.mem_read_data = bus_a.mem_read_data;
  assign bus_b.write_addr    = bus_a.write_addr;
  assign bus_b.RegWrite      = bus_a.RegWrite;
  assign bus_b.MemtoReg      = bus_a.MemtoReg;
  assign bus_b.rs1_addr      = bus_a.rs1_addr;
  assign bus_b.rs2_addr      = bus_a.rs2_addr;

  // Behavioural model: architectural registers plus one pending write
  logic [63:0] m_reg [32];
  logic        m_v;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic [63:0] m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 64'h0;
    m_v = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_data = 64'h0; m_cnt = 64'h0;
  endtask

  function automatic logic exp_wbv();
    return m_v && m_we && (m_rd != 5'd0);
  endfunction

  function automatic logic [63:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 64'h0;
    if (exp_wbv() && (m_rd == a)) return m_data;
    return m_reg[a];
  endfunction

  // One clock: present inputs, let the edge happen, advance the model
  task automatic cycle(input logic v, input logic we, input logic m2r,
                       input logic [4:0] rd, input logic [63:0] alu,
                       input logic [63:0] mem, input logic st, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus_a.in_valid = v; bus_a.RegWrite = we; bus_a.MemtoReg = m2r;
    bus_a.write_addr = rd; bus_a.alu_result = alu; bus_a.mem_read_data = mem;
    bus_a.stall = st; bus_a.flush = fl; bus_a.rs1_addr = r1; bus_a.rs2_addr = r2;
    @(posedge clk);
    if (!reset) begin
      if (exp_wbv() && !st) begin
        m_reg[m_rd] = m_data;
        m_cnt = m_cnt + 64'd1;
      end
      if (fl) m_v = 1'b0;
      else if (!st) m_v = v;
      if (!st) begin
        m_we = we; m_rd = rd; m_data = m2r ? mem : alu;
      end
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [63:0] val, input logic [4:0] r1);
    cycle(1'b1, 1'b1, 1'b0, rd, val, 64'h0, 1'b0, 1'b0, r1, 5'd0);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0, r1, r2);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("wb_valid", 64'(bus_a.wb_valid), 64'(exp_wbv()));
    if (exp_wbv()) begin
      chk("wb_addr", 64'(bus_a.wb_addr), 64'(m_rd));
      chk("wb_data", bus_a.wb_data, m_data);
    end
    chk("rs1_data", bus_a.rs1_data, exp_read(bus_a.rs1_addr));
    chk("rs2_data", bus_a.rs2_data, exp_read(bus_a.rs2_addr));
    chk("retire_count", bus_a.retire_count, m_cnt);
    chk("retire_small", 64'(bus_b.retire_count), 64'(m_cnt[2:0]));
    for (int i = 0; i < 32; i++) chk("register", bus_a.register[i], m_reg[i]);
  end

  initial begin
    model_reset();
    bus_a.in_valid = 1'b0; bus_a.RegWrite = 1'b0; bus_a.MemtoReg = 1'b0;
    bus_a.write_addr = 5'd0; bus_a.alu_result = 64'h0; bus_a.mem_read_data = 64'h0;
    bus_a.stall = 1'b0; bus_a.flush = 1'b0; bus_a.rs1_addr = 5'd0; bus_a.rs2_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", 64'(bus_a.wb_valid), 64'h0);
    chk("rst_wb_addr", 64'(bus_a.wb_addr), 64'h0);
    chk("rst_wb_data", bus_a.wb_data, 64'h0);
    chk("rst_retire", bus_a.retire_count, 64'h0);
    reset = 1'b0;

    // ALU writeback with bypass, then commit
    wr(5'd3, 64'h1234, 5'd3);
    chk("alu_wb_data", bus_a.wb_data, 64'h1234);
    chk("alu_bypass", bus_a.rs1_data, 64'h1234);
    chk("alu_x3_pending", bus_a.register[3], 64'h0);
    idle(5'd3, 5'd0);
    chk("alu_x3", bus_a.register[3], 64'h1234);
    chk("alu_retire", bus_a.retire_count, 64'd1);

    // Load writeback, then write to x0
    cycle(1'b1, 1'b1, 1'b1, 5'd7, 64'h55, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 5'd7, 5'd0);
    chk("load_bypass", bus_a.rs1_data, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle(1'b1, 1'b1, 1'b0, 5'd0, 64'd5, 64'h0, 1'b0, 1'b0, 5'd7, 5'd0);
    chk("load_x7", bus_a.register[7], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("x0_wb_valid", 64'(bus_a.wb_valid), 64'h0);
    chk("x0_rs2", bus_a.rs2_data, 64'h0);
    idle(5'd0, 5'd0);
    chk("x0_reg", bus_a.register[0], 64'h0);
    chk("x0_retire", bus_a.retire_count, 64'd2);

    // Stall holds the pending write; single commit on release
    wr(5'd9, 64'hAA, 5'd9);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 5'd9, 64'hBB, 64'h0, 1'b1, 1'b0, 5'd9, 5'd0);
      chk("stall_x9_held", bus_a.register[9], 64'h0);
      chk("stall_bypass", bus_a.rs1_data, 64'hAA);
      chk("stall_retire", bus_a.retire_count, 64'd2);
    end
    idle(5'd9, 5'd0);
    chk("stall_x9", bus_a.register[9], 64'hAA);
    chk("stall_retire_once", bus_a.retire_count, 64'd3);
    idle(5'd9, 5'd0);
    chk("stall_retire_after", bus_a.retire_count, 64'd3);

    // Flush together with stall: pending write dropped
    wr(5'd10, 64'h10, 5'd10);
    cycle(1'b1, 1'b1, 1'b0, 5'd11, 64'h11, 64'h0, 1'b1, 1'b1, 5'd10, 5'd0);
    chk("flst_wb_valid", 64'(bus_a.wb_valid), 64'h0);
    chk("flst_x10", bus_a.register[10], 64'h0);
    idle(5'd10, 5'd0);
    chk("flst_retire", bus_a.retire_count, 64'd3);

    // Flush on a commit edge: older commits, new content invalid
    wr(5'd12, 64'h12, 5'd12);
    cycle(1'b1, 1'b1, 1'b0, 5'd13, 64'h13, 64'h0, 1'b0, 1'b1, 5'd13, 5'd0);
    chk("flcm_x12", bus_a.register[12], 64'h12);
    chk("flcm_retire", bus_a.retire_count, 64'd4);
    chk("flcm_wb_valid", 64'(bus_a.wb_valid), 64'h0);
    idle(5'd13, 5'd0);
    chk("flcm_x13", bus_a.register[13], 64'h0);

    // Back-to-back writes to x4
    wr(5'd4, 64'd1, 5'd4);
    chk("b2b_rs1_1", bus_a.rs1_data, 64'd1);
    wr(5'd4, 64'd2, 5'd4);
    chk("b2b_rs1_2", bus_a.rs1_data, 64'd2);
    wr(5'd4, 64'd3, 5'd4);
    chk("b2b_rs1_3", bus_a.rs1_data, 64'd3);
    idle(5'd4, 5'd0);
    chk("b2b_x4", bus_a.register[4], 64'd3);
    chk("b2b_retire", bus_a.retire_count, 64'd7);
    chk("small_at_7", 64'(bus_b.retire_count), 64'd7);

    // 3-bit counter wraps from 7 to 0
    wr(5'd1, 64'hC0FFEE, 5'd1);
    idle(5'd1, 5'd0);
    chk("small_wrap", 64'(bus_b.retire_count), 64'd0);
    chk("wide_no_wrap", bus_a.retire_count, 64'd8);

    // Async reset mid-cycle, with a stalled write pending
    wr(5'd5, 64'hDEAD, 5'd5);
    wr(5'd6, 64'h66, 5'd6);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b0, 5'd6, 5'd5);
    chk("pre_rst_x5", bus_a.register[5], 64'hDEAD);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_x5", bus_a.register[5], 64'h0);
    chk("arst_retire", bus_a.retire_count, 64'h0);
    chk("arst_wb_valid", 64'(bus_a.wb_valid), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5'd6, 5'd5);
    chk("arst_x6_dropped", bus_a.register[6], 64'h0);

    // Randomized traffic; small rd range to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            rd, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(5'd0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
